// File: rtl/act_pkg.sv
// rtl/act_pkg.sv - shared types and constants for the activation stream controller
package act_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } act_state_t;

  localparam int          ACT_DWIDTH = 32;
  localparam logic [31:0] ACT_NAN    = 32'h7FC00000;

endpackage

// File: rtl/act_sync_fifo.sv
// rtl/act_sync_fifo.sv - synchronous FIFO with occupancy count, full and empty flags
module act_sync_fifo
  import act_pkg::*;
#(
  parameter int DWIDTH = ACT_DWIDTH,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DWIDTH-1:0]        push_data,
  input  logic                     pop,
  output logic [DWIDTH-1:0]        head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/act_stream_ctrl.sv
// rtl/act_stream_ctrl.sv - drives one activation core op at a time, results via output FIFO
module act_stream_ctrl
  import act_pkg::*;
#(
  parameter int                DWIDTH     = ACT_DWIDTH,
  parameter int                FIFO_DEPTH = 8,
  parameter int                TIMEOUT    = 64,
  parameter logic [DWIDTH-1:0] NAN_WORD   = ACT_NAN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DWIDTH-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DWIDTH-1:0] core_x,
  output logic              core_start,
  input  logic [DWIDTH-1:0] core_y,
  input  logic              core_valid,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              err_timeout,
  output logic [15:0]       done_count
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT) + 1;

  act_state_t        state_q;
  act_state_t        state_d;
  logic [TW-1:0]     timer_q;
  logic              accept;
  logic              push_req;
  logic              timeout_hit;
  logic [DWIDTH-1:0] push_data;
  logic [CW-1:0]     fifo_count;
  logic              fifo_full;
  logic              fifo_empty;

  // Accepting only with a free slot guarantees the single in-flight result always fits.
  assign in_ready   = (state_q == IDLE) && !rst && (fifo_count < CW'(FIFO_DEPTH));
  assign accept     = in_valid && in_ready;
  assign core_start = (state_q == ISSUE);
  assign out_valid  = !fifo_empty;

  always_comb begin
    state_d     = state_q;
    push_req    = 1'b0;
    push_data   = core_y;
    timeout_hit = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) state_d = ISSUE;
      end
      ISSUE: begin
        if (core_valid) begin
          push_req = 1'b1;
          state_d  = DRAIN;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          push_req    = 1'b1;
          push_data   = NAN_WORD;
          timeout_hit = 1'b1;
          state_d     = DRAIN;
        end
      end
      DRAIN: begin
        if (!core_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      core_x      <= '0;
      err_timeout <= 1'b0;
      done_count  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) core_x <= in_data;
      if (state_q == ISSUE && state_d == ISSUE) timer_q <= timer_q + TW'(1);
      else                                      timer_q <= '0;
      if (timeout_hit) err_timeout <= 1'b1;
      if (push_req)    done_count  <= done_count + 16'd1;
    end
  end

  act_sync_fifo #(
    .DWIDTH (DWIDTH),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_req && !fifo_full),
    .push_data (push_data),
    .pop       (out_ready),
    .head      (out_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_act_stream_ctrl.sv
// tb/tb_act_stream_ctrl.sv - randomized scoreboard bench for act_stream_ctrl
module tb_act_stream_ctrl;

  localparam logic [31:0] KEY   = 32'h3F000000;
  localparam logic [31:0] NAN   = 32'h7FC00000;
  localparam int          DEPTH = 8;
  localparam int          TMO   = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] core_x;
  logic        core_start;
  logic [31:0] core_y;
  logic        core_valid;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        err_timeout;
  logic [15:0] done_count;

  act_stream_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .core_x      (core_x),
    .core_start  (core_start),
    .core_y      (core_y),
    .core_valid  (core_valid),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .err_timeout (err_timeout),
    .done_count  (done_count)
  );

  always #5 clk = ~clk;

  // Behavioural core: answers x ^ KEY once start has been seen for core_lat cycles.
  int          core_lat = 12;
  bit          core_dead = 1'b0;
  bit          stale = 1'b0;
  int          core_cnt = 0;
  logic        core_valid_m = 1'b0;
  logic [31:0] core_y_m = '0;

  assign core_valid = core_valid_m | stale;
  assign core_y     = stale ? 32'hDEADBEEF : core_y_m;

  always @(posedge clk) begin
    if (rst || !core_start) begin
      core_cnt     <= 0;
      core_valid_m <= 1'b0;
    end else if (!core_valid_m && !core_dead) begin
      core_cnt <= core_cnt + 1;
      if (core_cnt + 1 >= core_lat) begin
        core_valid_m <= 1'b1;
        core_y_m     <= core_x ^ KEY;
      end
    end
  end

  int          compared = 0;
  int          mismatched = 0;
  logic [31:0] exp_q[$];
  int          exp_done = 0;
  int          ncyc = 0;
  int          s_cyc = 0;
  logic        s_in_hs, s_out_hs, s_in_ready, s_out_valid, s_start, s_core_valid, s_err;
  logic [31:0] s_out_data, s_core_x;
  logic [15:0] s_done;

  // One clock cycle: drive at the falling edge, sample just after, update the reference model.
  task automatic cycle(input logic v, input logic [31:0] d, input logic ordy);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    #1;
    s_in_ready   = in_ready;
    s_in_hs      = v && in_ready;
    s_out_valid  = out_valid;
    s_out_hs     = ordy && out_valid;
    s_out_data   = out_data;
    s_start      = core_start;
    s_core_valid = core_valid;
    s_core_x     = core_x;
    s_err        = err_timeout;
    s_done       = done_count;
    s_cyc        = ncyc;
    ncyc++;
    if (s_in_hs) begin
      exp_q.push_back(core_dead ? NAN : (d ^ KEY));
      exp_done++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cycle(1'b0, 32'h0, 1'b0);
    compared++;
    if ({s_in_ready, s_out_valid, s_start, s_err} !== 4'b0) begin
      mismatched++;
      $display("FAIL reset_flags got=%b exp=0000", {s_in_ready, s_out_valid, s_start, s_err});
    end
    compared++;
    if ({s_done, s_out_data, s_core_x} !== 80'h0) begin
      mismatched++;
      $display("FAIL reset_values got done=%h out=%h x=%h exp all zero", s_done, s_out_data, s_core_x);
    end
    rst = 1'b0;
    cycle(1'b0, 32'h0, 1'b0);
    compared++;
    if (s_in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL reset_release_in_ready got=%b exp=1", s_in_ready);
    end
  endtask

  task automatic test_single();
    int a, lat;
    logic [31:0] exp;
    core_lat = 12;
    core_dead = 1'b0;
    cycle(1'b1, 32'h0, 1'b1);
    compared++;
    if (s_in_hs !== 1'b1) begin
      mismatched++;
      $display("FAIL single_accept got=%b exp=1", s_in_hs);
    end
    a = s_cyc;
    lat = -1;
    for (int c = 0; c < 40 && !(lat >= 0 && s_in_ready); c++) begin
      cycle(1'b0, 32'h0, 1'b1);
      if (s_out_valid && lat < 0) begin
        lat = s_cyc - a;
        compared++;
        if (s_done !== 16'd1) begin
          mismatched++;
          $display("FAIL single_done got=%0d exp=1", s_done);
        end
      end
      if (s_out_hs) begin
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
        compared++;
        if (s_out_data !== exp || exp !== KEY) begin
          mismatched++;
          $display("FAIL single_data got=%h exp=%h", s_out_data, KEY);
        end
      end
    end
    compared++;
    if (lat !== 14) begin
      mismatched++;
      $display("FAIL single_latency got=%0d exp=14", lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ops[5];
    logic [31:0] exp;
    int idx = 0, pops = 0, viol = 0;
    bit prev = 1'b0;
    foreach (ops[i]) ops[i] = $urandom;
    core_lat = 12;
    for (int c = 0; c < 400 && !(idx == 5 && exp_q.size() == 0 && s_in_ready); c++) begin
      cycle(idx < 5, (idx < 5) ? ops[idx] : 32'h0, 1'b1);
      if (s_in_hs) idx++;
      if (s_in_ready && (s_start || s_core_valid)) viol++;
      if (s_start && !prev && s_core_valid) viol++;
      prev = s_start;
      if (s_out_hs) begin
        pops++;
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
        compared++;
        if (s_out_data !== exp) begin
          mismatched++;
          $display("FAIL b2b_data got=%h exp=%h", s_out_data, exp);
        end
      end
    end
    compared++;
    if (pops !== 5) begin
      mismatched++;
      $display("FAIL b2b_count got=%0d exp=5", pops);
    end
    compared++;
    if (viol !== 0) begin
      mismatched++;
      $display("FAIL b2b_handshake got=%0d violations exp=0", viol);
    end
    compared++;
    if (s_done !== 16'(exp_done)) begin
      mismatched++;
      $display("FAIL b2b_done got=%0d exp=%0d", s_done, exp_done);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] ops[10];
    logic [31:0] exp;
    int idx = 0, pops = 0;
    foreach (ops[i]) ops[i] = $urandom;
    core_lat = 12;
    for (int c = 0; c < 200; c++) begin
      cycle(idx < 10, (idx < 10) ? ops[idx] : 32'h0, 1'b0);
      if (s_in_hs) idx++;
    end
    compared++;
    if (idx !== DEPTH) begin
      mismatched++;
      $display("FAIL bp_accepted got=%0d exp=%0d", idx, DEPTH);
    end
    compared++;
    if (s_in_ready !== 1'b0 || s_out_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL bp_stall got in_ready=%b out_valid=%b exp 0/1", s_in_ready, s_out_valid);
    end
    for (int c = 0; c < 600 && !(idx == 10 && exp_q.size() == 0 && s_in_ready); c++) begin
      cycle(idx < 10, (idx < 10) ? ops[idx] : 32'h0, 1'($urandom_range(0, 1)));
      if (s_in_hs) idx++;
      if (s_out_hs) begin
        pops++;
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
        compared++;
        if (s_out_data !== exp) begin
          mismatched++;
          $display("FAIL bp_data got=%h exp=%h", s_out_data, exp);
        end
      end
    end
    compared++;
    if (pops !== 10) begin
      mismatched++;
      $display("FAIL bp_results got=%0d exp=10", pops);
    end
  endtask

  task automatic test_random();
    logic [31:0] d, exp;
    int idx = 0, pops = 0;
    d = $urandom;
    for (int c = 0; c < 3000 && !(idx == 20 && exp_q.size() == 0 && s_in_ready); c++) begin
      core_lat = $urandom_range(1, 10);
      cycle((idx < 20) && ($urandom_range(0, 2) != 0), d, ($urandom_range(0, 3) != 0));
      if (s_in_hs) begin
        idx++;
        d = $urandom;
      end
      if (s_out_hs) begin
        pops++;
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
        compared++;
        if (s_out_data !== exp) begin
          mismatched++;
          $display("FAIL rand_data got=%h exp=%h", s_out_data, exp);
        end
      end
    end
    compared++;
    if (pops !== 20) begin
      mismatched++;
      $display("FAIL rand_results got=%0d exp=20", pops);
    end
    compared++;
    if (s_done !== 16'(exp_done)) begin
      mismatched++;
      $display("FAIL rand_done got=%0d exp=%0d", s_done, exp_done);
    end
  endtask

  task automatic test_timeout();
    int a, lat = -1, starts = 0;
    bit sent = 1'b0, got = 1'b0;
    logic [31:0] d, exp;
    core_dead = 1'b1;
    cycle(1'b1, $urandom, 1'b1);
    compared++;
    if (s_in_hs !== 1'b1) begin
      mismatched++;
      $display("FAIL tmo_accept got=%b exp=1", s_in_hs);
    end
    a = s_cyc;
    for (int c = 0; c < 100 && lat < 0; c++) begin
      cycle(1'b0, 32'h0, 1'b1);
      if (s_start) starts++;
      if (s_out_valid) begin
        lat = s_cyc - a;
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
        compared++;
        if (s_out_data !== exp || exp !== NAN) begin
          mismatched++;
          $display("FAIL tmo_data got=%h exp=%h", s_out_data, NAN);
        end
        compared++;
        if (s_err !== 1'b1) begin
          mismatched++;
          $display("FAIL tmo_err got=%b exp=1", s_err);
        end
      end
    end
    compared++;
    if (starts !== TMO) begin
      mismatched++;
      $display("FAIL tmo_start_cycles got=%0d exp=%0d", starts, TMO);
    end
    compared++;
    if (lat !== TMO + 1) begin
      mismatched++;
      $display("FAIL tmo_latency got=%0d exp=%0d", lat, TMO + 1);
    end
    core_dead = 1'b0;
    core_lat = 5;
    d = $urandom;
    for (int c = 0; c < 60 && !got; c++) begin
      cycle(!sent, d, 1'b1);
      if (s_in_hs) sent = 1'b1;
      if (s_out_hs) begin
        got = 1'b1;
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
        compared++;
        if (s_out_data !== exp) begin
          mismatched++;
          $display("FAIL tmo_recover_data got=%h exp=%h", s_out_data, exp);
        end
      end
    end
    compared++;
    if (!got) begin
      mismatched++;
      $display("FAIL tmo_recover got=no result exp=one result");
    end
    compared++;
    if (s_err !== 1'b1) begin
      mismatched++;
      $display("FAIL tmo_sticky got=%b exp=1", s_err);
    end
  endtask

  task automatic test_reset_mid_op();
    int idx = 0;
    core_lat = 12;
    for (int c = 0; c < 150 && idx < 4; c++) begin
      cycle(1'b1, $urandom, 1'b0);
      if (s_in_hs) idx++;
    end
    repeat (3) cycle(1'b0, 32'h0, 1'b0);
    compared++;
    if (idx !== 4 || s_start !== 1'b1 || s_out_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL rmo_setup got acc=%0d start=%b out_valid=%b exp 4/1/1", idx, s_start, s_out_valid);
    end
    rst = 1'b1;
    cycle(1'b0, 32'h0, 1'b0);
    compared++;
    if (s_in_ready !== 1'b0) begin
      mismatched++;
      $display("FAIL rmo_in_ready_in_reset got=%b exp=0", s_in_ready);
    end
    rst = 1'b0;
    exp_q.delete();
    exp_done = 0;
    cycle(1'b0, 32'h0, 1'b0);
    compared++;
    if ({s_out_valid, s_start, s_err, s_done} !== 19'h0) begin
      mismatched++;
      $display("FAIL rmo_cleared got out_valid=%b start=%b err=%b done=%0d exp all zero",
               s_out_valid, s_start, s_err, s_done);
    end
    compared++;
    if (s_in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL rmo_in_ready got=%b exp=1", s_in_ready);
    end
  endtask

  task automatic test_stale_valid();
    int seen = 0;
    stale = 1'b1;
    cycle(1'b0, 32'h0, 1'b1);
    stale = 1'b0;
    for (int c = 0; c < 6; c++) begin
      cycle(1'b0, 32'h0, 1'b1);
      if (s_out_valid) seen++;
    end
    compared++;
    if (seen !== 0) begin
      mismatched++;
      $display("FAIL stale_push got=%0d valid cycles exp=0", seen);
    end
    compared++;
    if (s_done !== 16'(exp_done)) begin
      mismatched++;
      $display("FAIL stale_done got=%0d exp=%0d", s_done, exp_done);
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_timeout();
    test_reset_mid_op();
    test_stale_valid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
